// File: rtl/pc_mem_if.sv
// Multicycle fetch/memory-access stage: owns PC, IR and MDR and sequences
// dual-port block-RAM accesses, returning a one-cycle done pulse to the control FSM.
module pc_mem_if #(
    parameter int unsigned          ADDR_W   = 8,
    parameter int unsigned          DATA_W   = 32,
    parameter int unsigned          RD_LAT   = 1,
    parameter logic [DATA_W-1:0]    RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_req,
    input  logic              lorD,
    input  logic              MemWrite,
    input  logic              IRWrite,
    input  logic              PCWrite,
    input  logic              Branch,
    input  logic              zero,
    input  logic [1:0]        PCSrc,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] store_data,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] mdr,
    output logic              mem_done,
    output logic              mem_busy,
    output logic              mem_err,
    output logic              ena,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dina,
    output logic              enb,
    output logic [ADDR_W-1:0] addrb,
    input  logic [DATA_W-1:0] doutb
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [1:0] CNT_INIT = 2'(RD_LAT);

    state_t            state_q;
    logic [1:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic              irw_q;
    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] pc_d;
    logic [DATA_W-1:0] instr_q;
    logic [DATA_W-1:0] mdr_q;
    logic              done_q;
    logic              busy_q;
    logic              err_q;

    logic [DATA_W-1:0] sel_c;
    logic [ADDR_W-1:0] word_c;
    logic              aligned_c;
    logic              req_ok_c;
    logic              pc_en_c;
    logic              unused_c;

    // Address select; bits above the RAM word address are dropped so addresses wrap.
    assign sel_c     = lorD ? alu_out : pc_q;
    assign word_c    = sel_c[ADDR_W+1:2];
    assign aligned_c = (sel_c[1:0] == 2'b00);
    assign unused_c  = ^sel_c[DATA_W-1:ADDR_W+2];

    // RAM strobes must fire in the request cycle itself, so they are decoded from inputs.
    assign req_ok_c = !rst_n && (state_q == IDLE) && mem_req && aligned_c;
    assign ena      = req_ok_c && MemWrite;
    assign wea      = req_ok_c && MemWrite;
    assign enb      = req_ok_c && !MemWrite;
    assign addra    = word_c;
    assign dina     = store_data;
    assign addrb    = (state_q == IDLE) ? word_c : addr_q;

    assign pc_en_c = PCWrite | (Branch & zero);

    always_comb begin
        pc_d = pc_q;
        case (PCSrc)
            2'b00:   pc_d = alu_result;
            2'b01:   pc_d = alu_out;
            2'b10:   pc_d = {pc_q[DATA_W-1:28], instr_q[25:0], 2'b00};
            default: pc_d = pc_q;
        endcase
    end

    // Access sequencer plus PC/IR/MDR state.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            addr_q  <= '0;
            irw_q   <= 1'b0;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            mdr_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (pc_en_c) begin
                pc_q <= pc_d;
            end
            case (state_q)
                IDLE: begin
                    if (mem_req) begin
                        if (!aligned_c) begin
                            err_q <= 1'b1;
                        end else if (MemWrite) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b1;
                        end else begin
                            addr_q  <= word_c;
                            irw_q   <= IRWrite;
                            cnt_q   <= CNT_INIT;
                            state_q <= RD_WAIT;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                RD_WAIT: begin
                    if (cnt_q == 2'd1) begin
                        if (irw_q) begin
                            instr_q <= doutb;
                        end else begin
                            mdr_q <= doutb;
                        end
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pc       = pc_q;
    assign instr    = instr_q;
    assign mdr      = mdr_q;
    assign mem_done = done_q;
    assign mem_busy = busy_q;
    assign mem_err  = err_q;

endmodule

// File: tb/tb_pc_mem_if.sv
// Directed bench for pc_mem_if: behavioural dual-port RAM, scoreboard of
// expected IR/MDR contents and done-pulse cycle, plus direct strobe/PC checks.
module tb_pc_mem_if;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned RD_LAT = 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              mem_req, lorD, MemWrite, IRWrite, PCWrite, Branch, zero;
    logic [1:0]        PCSrc;
    logic [DATA_W-1:0] alu_result, alu_out, store_data;
    logic [DATA_W-1:0] pc, instr, mdr;
    logic              mem_done, mem_busy, mem_err;
    logic              ena, wea, enb;
    logic [ADDR_W-1:0] addra, addrb;
    logic [DATA_W-1:0] dina, doutb;

    pc_mem_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .lorD(lorD), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .Branch(Branch), .zero(zero), .PCSrc(PCSrc),
        .alu_result(alu_result), .alu_out(alu_out), .store_data(store_data),
        .pc(pc), .instr(instr), .mdr(mdr), .mem_done(mem_done), .mem_busy(mem_busy),
        .mem_err(mem_err), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .enb(enb), .addrb(addrb), .doutb(doutb)
    );

    always #5 clk = ~clk;

    // Behavioural RAM (read latency 1) with a bench-side preload port.
    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rd_q;
    logic              pl_en = 1'b0;
    logic [ADDR_W-1:0] pl_addr;
    logic [DATA_W-1:0] pl_data;
    always @(posedge clk) begin
        if (pl_en) ram[pl_addr] <= pl_data;
        else if (ena && wea) ram[addra] <= dina;
        if (enb) rd_q <= ram[addrb];
    end
    assign doutb = rd_q;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] mdr;
        int unsigned cyc;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_instr = 32'h0;
    logic [31:0] exp_mdr   = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(posedge clk) begin
        #1;
        if (mem_done) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done at cycle %0d required none", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                chk("done_cycle", 32'(cyc), 32'(mon_e.cyc));
                chk("instr", instr, mon_e.instr);
                chk("mdr", mdr, mon_e.mdr);
            end
        end
    end

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic do_read(input logic lord, input logic irw, input logic [31:0] aout,
                           input logic [31:0] val, input logic [ADDR_W-1:0] exp_addr);
        @(negedge clk);
        lorD = lord; IRWrite = irw; MemWrite = 1'b0; alu_out = aout; mem_req = 1'b1;
        if (irw) exp_instr = val; else exp_mdr = val;
        sb_q.push_back('{exp_instr, exp_mdr, cyc + RD_LAT + 1});
        #1;
        chk("rd_enb", 32'(enb), 32'd1);
        chk("rd_ena", 32'(ena), 32'd0);
        chk("rd_addrb", 32'(addrb), 32'(exp_addr));
        @(negedge clk);
        mem_req = 1'b0; IRWrite = 1'b0; lorD = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] aout, input logic [31:0] data,
                            input logic [ADDR_W-1:0] exp_addr);
        @(negedge clk);
        lorD = 1'b1; MemWrite = 1'b1; alu_out = aout; store_data = data; mem_req = 1'b1;
        sb_q.push_back('{exp_instr, exp_mdr, cyc + 1});
        #1;
        chk("wr_ena_wea", {30'd0, ena, wea}, 32'd3);
        chk("wr_enb", 32'(enb), 32'd0);
        chk("wr_addra", 32'(addra), 32'(exp_addr));
        chk("wr_dina", dina, data);
        @(negedge clk);
        mem_req = 1'b0; MemWrite = 1'b0; lorD = 1'b0;
        #1;
        chk("wr_wea_drop", 32'(wea), 32'd0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: got %0d pending required 0", sb_q.size());
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic pc_step(input logic pcw, input logic br, input logic z, input logic [1:0] src,
                           input logic [31:0] ares, input logic [31:0] aout, input logic [31:0] exp_pc,
                           input string name);
        @(negedge clk);
        PCWrite = pcw; Branch = br; zero = z; PCSrc = src; alu_result = ares; alu_out = aout;
        @(negedge clk);
        PCWrite = 1'b0; Branch = 1'b0; zero = 1'b0; PCSrc = 2'b11;
        #1;
        chk(name, pc, exp_pc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; mem_req = 1'b0; lorD = 1'b0; MemWrite = 1'b0; IRWrite = 1'b0;
        PCWrite = 1'b0; Branch = 1'b0; zero = 1'b0; PCSrc = 2'b11;
        alu_result = 32'h0; alu_out = 32'h0; store_data = 32'h0;

        // Reset held while the RAM image is loaded.
        preload(8'd0,  32'h8C010004);
        preload(8'd4,  32'hDEADBEEF);
        preload(8'd8,  32'h08000010);
        preload(8'd16, 32'hCAFEF00D);
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_mdr", mdr, 32'h0);
        chk("rst_strobes", {26'd0, mem_done, mem_busy, mem_err, ena, wea, enb}, 32'h0);
        @(negedge clk);
        rst_n = 1'b0;

        // Fetch, load, store and store readback.
        do_read(1'b0, 1'b1, 32'h0, 32'h8C010004, 8'd0);
        wait_idle();
        do_read(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 8'd4);
        wait_idle();
        do_write(32'h8, 32'h12345678, 8'd2);
        wait_idle();
        do_read(1'b1, 1'b0, 32'h8, 32'h12345678, 8'd2);
        wait_idle();

        // PC update sources.
        pc_step(1'b1, 1'b0, 1'b0, 2'b00, 32'h4,   32'h0,  32'h4,  "pc_write_alu");
        pc_step(1'b0, 1'b1, 1'b0, 2'b00, 32'h100, 32'h0,  32'h4,  "pc_branch_nt");
        pc_step(1'b0, 1'b1, 1'b1, 2'b01, 32'h100, 32'h20, 32'h20, "pc_branch_t");
        do_read(1'b1, 1'b1, 32'h20, 32'h08000010, 8'd8);
        wait_idle();
        pc_step(1'b1, 1'b0, 1'b0, 2'b10, 32'h0, 32'h0, 32'h40, "pc_jump");
        pc_step(1'b1, 1'b0, 1'b0, 2'b11, 32'h8, 32'h8, 32'h40, "pc_hold");

        // Fetch from pc=0x40 while a new request and a PC update arrive in RD_WAIT.
        do_read(1'b0, 1'b1, 32'h0, 32'hCAFEF00D, 8'd16);
        mem_req = 1'b1; MemWrite = 1'b1; lorD = 1'b1; alu_out = 32'h0;
        PCWrite = 1'b1; PCSrc = 2'b00; alu_result = 32'h44;
        #1;
        chk("busy_req_ena", {30'd0, ena, enb}, 32'h0);
        chk("busy_flag", 32'(mem_busy), 32'd1);
        chk("busy_addrb", 32'(addrb), 32'd16);
        @(negedge clk);
        mem_req = 1'b0; MemWrite = 1'b0; lorD = 1'b0; PCWrite = 1'b0; PCSrc = 2'b11;
        wait_idle();
        chk("pc_during_rd", pc, 32'h44);

        // Misaligned request.
        @(negedge clk);
        mem_req = 1'b1; lorD = 1'b1; alu_out = 32'h6;
        #1;
        chk("mis_strobes", {30'd0, ena, enb}, 32'h0);
        @(negedge clk);
        mem_req = 1'b0; lorD = 1'b0;
        #1;
        chk("mis_err", {30'd0, mem_err, mem_busy}, 32'h2);
        @(negedge clk);
        chk("mis_err_drop", 32'(mem_err), 32'd0);

        // Address wrap.
        do_read(1'b1, 1'b0, 32'h400, 32'h8C010004, 8'd0);
        wait_idle();

        // Reset during RD_WAIT aborts the access.
        @(negedge clk);
        mem_req = 1'b1; lorD = 1'b1; alu_out = 32'h10; IRWrite = 1'b0;
        @(negedge clk);
        mem_req = 1'b0; lorD = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_busy", 32'(mem_busy), 32'd0);
        chk("abort_mdr", mdr, 32'h0);
        chk("abort_pc", pc, 32'h0);
        chk("abort_instr", instr, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
